// File: rtl/feature_requant_serializer.sv
// rtl/feature_requant_serializer.sv - captures a beat of parallel conv outputs and emits them one by one, requantized
// Optional build macro REQUANT_ROUND_EN: round half up before the shift instead of truncating.
module feature_requant_serializer #(
  parameter int NUM_FILTERS = 6,
  parameter int IN_W        = 16,
  parameter int OUT_W       = 8,
  parameter int SHIFT       = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_features_valid,
  input  logic [NUM_FILTERS*IN_W-1:0]   i_features,
  output logic                          o_ready,
  output logic                          o_feature_valid,
  output logic signed [OUT_W-1:0]       o_feature,
  output logic                          o_sat,
  output logic                          o_last,
  input  logic                          i_ready
);

  localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-(2**(OUT_W-1)));
`ifdef REQUANT_ROUND_EN
  localparam logic signed [IN_W:0] ROUND = (IN_W+1)'(2**(SHIFT-1));
`endif

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_d;
  logic signed [IN_W-1:0]  bank_q [NUM_FILTERS];
  logic                    capture;
  logic                    advance;
  logic                    finish;
  logic signed [IN_W-1:0]  next_in;
  logic [OUT_W:0]          rq;

  // Returns {sat, value}; the extra bit keeps headroom for the rounding add.
  function automatic logic [OUT_W:0] requant(input logic signed [IN_W-1:0] f);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] shd;
    ext = {f[IN_W-1], f};
`ifdef REQUANT_ROUND_EN
    ext = ext + ROUND;
`endif
    shd = ext >>> SHIFT;
    if (shd > SAT_MAX)
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (shd < SAT_MIN)
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    else
      return {1'b0, shd[OUT_W-1:0]};
  endfunction

  assign o_ready = (state_q == ST_IDLE) || ((idx_q == LAST_IDX) && i_ready);
  assign capture = i_features_valid && o_ready;
  assign advance = (state_q == ST_EMIT) && i_ready && (idx_q != LAST_IDX);
  assign finish  = (state_q == ST_EMIT) && i_ready && (idx_q == LAST_IDX);
  // Wrap to 0 at the last index so the bank read below never goes out of range.
  assign idx_d   = (capture || idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    next_in = bank_q[idx_d];
    if (capture) next_in = i_features[IN_W-1:0];
  end

  assign rq = requant(next_in);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      o_feature_valid <= 1'b0;
      o_feature       <= '0;
      o_sat           <= 1'b0;
      o_last          <= 1'b0;
    end else begin
      if (capture || advance) begin
        idx_q     <= idx_d;
        o_feature <= rq[OUT_W-1:0];
        o_sat     <= rq[OUT_W];
        o_last    <= (idx_d == LAST_IDX);
      end
      if (capture) begin
        state_q         <= ST_EMIT;
        o_feature_valid <= 1'b1;
      end else if (finish) begin
        state_q         <= ST_IDLE;
        o_feature_valid <= 1'b0;
        o_last          <= 1'b0;
      end
    end
  end

  // Bank is deliberately unreset; its contents only matter after a capture.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      for (int k = 0; k < NUM_FILTERS; k++)
        bank_q[k] <= i_features[k*IN_W +: IN_W];
    end
  end

endmodule

// File: tb/tb_feature_requant_serializer.sv
// tb/tb_feature_requant_serializer.sv - directed self-checking bench for feature_requant_serializer
module tb_feature_requant_serializer;
  localparam int N  = 6;
  localparam int IW = 16;
  localparam int OW = 8;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n;
  logic                   i_features_valid;
  logic [N*IW-1:0]        i_features;
  logic                   o_ready;
  logic                   o_feature_valid;
  logic signed [OW-1:0]   o_feature;
  logic                   o_sat;
  logic                   o_last;
  logic                   i_ready;

  int total = 0;
  int bad   = 0;

  int A_IN[6]  = '{24, -24, 291, 0, 1, -1};
  int S_IN[6]  = '{32'h7FFF, -32768, 32'h07F0, 0, 0, 0};
  int B_IN[6]  = '{-100, 100, 4000, -4000, 15, -17};
`ifdef REQUANT_ROUND_EN
  int A_EXP[6] = '{2, -1, 18, 0, 0, 0};
  int B_EXP[6] = '{-6, 6, 127, -128, 1, -1};
`else
  int A_EXP[6] = '{1, -2, 18, 0, 0, -1};
  int B_EXP[6] = '{-7, 6, 127, -128, 0, -2};
`endif
  int A_SAT[6] = '{0, 0, 0, 0, 0, 0};
  int S_EXP[6] = '{127, -128, 127, 0, 0, 0};
  int S_SAT[6] = '{1, 1, 0, 0, 0, 0};
  int B_SAT[6] = '{0, 0, 1, 1, 0, 0};

  feature_requant_serializer #(
    .NUM_FILTERS(N), .IN_W(IW), .OUT_W(OW), .SHIFT(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_features_valid(i_features_valid),
    .i_features(i_features),
    .o_ready(o_ready),
    .o_feature_valid(o_feature_valid),
    .o_feature(o_feature),
    .o_sat(o_sat),
    .o_last(o_last),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input int v[6]);
    for (int k = 0; k < N; k++) i_features[k*IW +: IW] = v[k][IW-1:0];
  endtask

  // Checks six consecutive outputs with i_ready high; returns on the last-filter cycle.
  task automatic expect_beat(input string tag, input int exp[6], input int sat[6]);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s valid[%0d]", tag, k), int'(o_feature_valid), 1);
      chk($sformatf("%s feat[%0d]", tag, k), int'(o_feature), exp[k]);
      chk($sformatf("%s sat[%0d]", tag, k), int'(o_sat), sat[k]);
      chk($sformatf("%s last[%0d]", tag, k), int'(o_last), (k == N-1) ? 1 : 0);
      chk($sformatf("%s ready[%0d]", tag, k), int'(o_ready), (k == N-1) ? 1 : 0);
      if (k < N-1) tick();
    end
  endtask

  task automatic send(input int v[6]);
    load(v);
    i_features_valid = 1'b1;
    tick();
    i_features_valid = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, " valid"}, int'(o_feature_valid), 0);
    chk({tag, " ready"}, int'(o_ready), 1);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_features_valid = 1'b0;
    i_features = '0;
    i_ready = 1'b1;
    tick();
    tick();
    chk("rst valid", int'(o_feature_valid), 0);
    chk("rst feat", int'(o_feature), 0);
    chk("rst sat", int'(o_sat), 0);
    chk("rst last", int'(o_last), 0);
    i_rst_n = 1'b1;
    #1;
    chk("rst ready", int'(o_ready), 1);

    // basic requant of a mixed-sign beat
    send(A_IN);
    expect_beat("basic", A_EXP, A_SAT);
    tick();
    expect_idle("basic end");

    // saturation boundaries
    send(S_IN);
    expect_beat("sat", S_EXP, S_SAT);
    tick();
    expect_idle("sat end");

    // downstream stall at idx 2
    send(A_IN);
    tick();
    tick();
    chk("stall pre feat", int'(o_feature), A_EXP[2]);
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall feat c%0d", c), int'(o_feature), A_EXP[2]);
      chk($sformatf("stall valid c%0d", c), int'(o_feature_valid), 1);
      chk($sformatf("stall ready c%0d", c), int'(o_ready), 0);
      tick();
    end
    i_ready = 1'b1;
    #1;
    for (int k = 2; k < N; k++) begin
      chk($sformatf("resume feat[%0d]", k), int'(o_feature), A_EXP[k]);
      chk($sformatf("resume last[%0d]", k), int'(o_last), (k == N-1) ? 1 : 0);
      tick();
    end
    expect_idle("stall end");

    // back-to-back beats with upstream always valid
    load(A_IN);
    i_features_valid = 1'b1;
    tick();
    load(B_IN);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("b2b A feat[%0d]", k), int'(o_feature), A_EXP[k]);
      chk($sformatf("b2b A ready[%0d]", k), int'(o_ready), (k == N-1) ? 1 : 0);
      tick();
    end
    i_features_valid = 1'b0;
    expect_beat("b2b B", B_EXP, B_SAT);
    tick();
    expect_idle("b2b end");

    // reset mid-emit at idx 3
    send(A_IN);
    tick();
    tick();
    tick();
    chk("mid rst pre feat", int'(o_feature), A_EXP[3]);
    i_rst_n = 1'b0;
    tick();
    chk("mid rst valid", int'(o_feature_valid), 0);
    chk("mid rst feat", int'(o_feature), 0);
    chk("mid rst last", int'(o_last), 0);
    chk("mid rst ready", int'(o_ready), 1);
    i_rst_n = 1'b1;
    tick();
    expect_idle("post rst idle");
    send(B_IN);
    expect_beat("post rst", B_EXP, B_SAT);
    tick();
    expect_idle("post rst end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
